// File: rtl/tick_sched.sv
// Timestep generator for the SNN core grid: issues a tick after the fabric has drained
// (DRAIN), or periodically at a programmable period while a sequence runs (FREERUN).
module tick_sched #(
    parameter int NUM_CORES    = 6,
    parameter int QUIET_CYCLES = 5,
    parameter int PERIOD_W     = 32,
    parameter int TCNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 input_empty,
    input  logic                 grid_idle,
    input  logic [NUM_CORES-1:0] core_empty,
    input  logic                 start_seq,
    input  logic                 complete,
    input  logic [PERIOD_W-1:0]  period,
    output logic                 tick,
    output logic [TCNT_W-1:0]    tick_count,
    output logic                 busy,
    output logic [1:0]           sched_state
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_FREERUN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [QW-1:0]       quiet_cnt_q, quiet_cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic                tick_q, tick_d;
    logic [TCNT_W-1:0]   tick_count_q, tick_count_d;
    logic                busy_q, busy_d;
    logic                quiet;

    assign quiet = input_empty & grid_idle & (&core_empty);

    always_comb begin
        state_d      = state_q;
        quiet_cnt_d  = quiet_cnt_q;
        period_d     = period_q;
        period_cnt_d = period_cnt_q;
        tick_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!input_empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!quiet) begin
                    quiet_cnt_d = '0;
                end else if (quiet_cnt_q == QUIET_LAST) begin
                    quiet_cnt_d = '0;
                    tick_d      = 1'b1;
                    state_d     = ST_WAIT;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + QW'(1);
                end
            end
            ST_WAIT: begin
                if (!input_empty) begin
                    state_d = ST_DRAIN;
                end else if (start_seq) begin
                    state_d      = ST_FREERUN;
                    period_d     = period;
                    period_cnt_d = '0;
                end
            end
            ST_FREERUN: begin
                // The period is only sampled on entry; a zero period parks here silently.
                if (complete) begin
                    state_d      = ST_IDLE;
                    period_cnt_d = '0;
                end else if (period_q == '0) begin
                    period_cnt_d = '0;
                end else if (period_cnt_q == period_q - PERIOD_W'(1)) begin
                    period_cnt_d = '0;
                    tick_d       = 1'b1;
                end else begin
                    period_cnt_d = period_cnt_q + PERIOD_W'(1);
                end
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            quiet_cnt_d  = '0;
            period_cnt_d = '0;
            tick_d       = 1'b0;
        end

        // The count moves in the same edge as the tick pulse, so both appear together.
        tick_count_d = tick_d ? tick_count_q + TCNT_W'(1) : tick_count_q;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            quiet_cnt_q  <= '0;
            period_q     <= '0;
            period_cnt_q <= '0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            quiet_cnt_q  <= quiet_cnt_d;
            period_q     <= period_d;
            period_cnt_q <= period_cnt_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            busy_q       <= busy_d;
        end
    end

    assign tick        = tick_q;
    assign tick_count  = tick_count_q;
    assign busy        = busy_q;
    assign sched_state = state_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed, table-driven bench for tick_sched: drain ticks, free-run ticks, abort, wrap.
module tb_tick_sched;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DR   = 2'd1;
    localparam logic [1:0] WT   = 2'd2;
    localparam logic [1:0] FR   = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        input_empty;
    logic        grid_idle;
    logic [5:0]  core_empty;
    logic        start_seq;
    logic        complete;
    logic [31:0] period;
    logic        tick;
    logic [15:0] tick_count;
    logic        busy;
    logic [1:0]  sched_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ie;
        logic        gi;
        logic [5:0]  ce;
        logic        ss;
        logic        cp;
        logic [31:0] per;
        logic        ab;
        logic        eTick;
        logic [1:0]  eState;
        logic [15:0] eCount;
    } vec_t;

    vec_t vecs[$];

    tick_sched #(
        .NUM_CORES(6), .QUIET_CYCLES(5), .PERIOD_W(32), .TCNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .input_empty(input_empty), .grid_idle(grid_idle), .core_empty(core_empty),
        .start_seq(start_seq), .complete(complete), .period(period),
        .tick(tick), .tick_count(tick_count), .busy(busy), .sched_state(sched_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic ie, input logic gi, input logic [5:0] ce,
                                   input logic ss, input logic cp, input logic [31:0] per,
                                   input logic ab, input logic eTick, input logic [1:0] eState,
                                   input logic [15:0] eCount);
        vec_t v;
        v.ie = ie; v.gi = gi; v.ce = ce; v.ss = ss; v.cp = cp; v.per = per; v.ab = ab;
        v.eTick = eTick; v.eState = eState; v.eCount = eCount;
        return v;
    endfunction

    function automatic void addVec(input logic ie, input logic gi, input logic [5:0] ce,
                                   input logic ss, input logic cp, input logic [31:0] per,
                                   input logic ab, input logic eTick, input logic [1:0] eState,
                                   input logic [15:0] eCount);
        vecs.push_back(mkVec(ie, gi, ce, ss, cp, per, ab, eTick, eState, eCount));
    endfunction

    // n fully quiet cycles with no tick expected
    function automatic void addQuiet(input int n, input logic [31:0] per,
                                     input logic [1:0] eState, input logic [15:0] eCount);
        for (int k = 0; k < n; k++) addVec(1, 1, 6'h3F, 0, 0, per, 0, 0, eState, eCount);
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        input_empty = v.ie;
        grid_idle   = v.gi;
        core_empty  = v.ce;
        start_seq   = v.ss;
        complete    = v.cp;
        period      = v.per;
        abort       = v.ab;
    endtask

    task automatic checkOutput(input string name, input logic expTick,
                               input logic [1:0] expState, input logic [15:0] expCount);
        logic expBusy;
        expBusy = (expState != IDLE);
        checks++;
        if (tick !== expTick || sched_state !== expState || busy !== expBusy ||
            tick_count !== expCount) begin
            errors++;
            $display("[TB] FAIL %s: got tick=%0b state=%0d busy=%0b count=%0h, want tick=%0b state=%0d busy=%0b count=%0h",
                     name, tick, sched_state, busy, tick_count,
                     expTick, expState, expBusy, expCount);
        end
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(name, v.eTick, v.eState, v.eCount);
    endtask

    initial begin
        // Drain after one busy input cycle: tick five quiet cycles later
        addVec(0, 1, 6'h3F, 0, 0, 0, 0, 0, DR, 0);
        addQuiet(4, 0, DR, 0);
        addVec(1, 1, 6'h3F, 0, 0, 0, 0, 1, WT, 1);
        addQuiet(1, 0, WT, 1);
        // A single non-empty core restarts the quiet run
        addVec(0, 1, 6'h3F, 0, 0, 0, 0, 0, DR, 1);
        addQuiet(4, 0, DR, 1);
        addVec(1, 1, 6'h3E, 0, 0, 0, 0, 0, DR, 1);
        addQuiet(4, 0, DR, 1);
        addVec(1, 1, 6'h3F, 0, 0, 0, 0, 1, WT, 2);
        // Free-run with period 4; the later change to 2 must be ignored
        addVec(1, 1, 6'h3F, 1, 0, 4, 0, 0, FR, 2);
        addQuiet(3, 4, FR, 2);
        addVec(1, 1, 6'h3F, 0, 0, 2, 0, 1, FR, 3);
        addQuiet(3, 2, FR, 3);
        addVec(1, 1, 6'h3F, 0, 0, 2, 0, 1, FR, 4);
        addQuiet(3, 2, FR, 4);
        addVec(1, 1, 6'h3F, 0, 0, 2, 0, 1, FR, 5);
        // complete on the matching cycle wins over the tick
        addQuiet(3, 2, FR, 5);
        addVec(1, 1, 6'h3F, 0, 1, 2, 0, 0, IDLE, 5);
        // abort on the last quiet cycle suppresses the tick and clears the quiet run
        addVec(0, 1, 6'h3F, 0, 0, 0, 0, 0, DR, 5);
        addQuiet(4, 0, DR, 5);
        addVec(1, 1, 6'h3F, 0, 0, 0, 1, 0, IDLE, 5);
        addVec(0, 1, 6'h3F, 0, 0, 0, 0, 0, DR, 5);
        addQuiet(4, 0, DR, 5);
        addVec(1, 1, 6'h3F, 0, 0, 0, 0, 1, WT, 6);
        // In WAIT, pending input beats start_seq; grid not idle breaks the run
        addVec(0, 1, 6'h3F, 1, 0, 0, 0, 0, DR, 6);
        addQuiet(2, 0, DR, 6);
        addVec(1, 0, 6'h3F, 0, 0, 0, 0, 0, DR, 6);
        addQuiet(4, 0, DR, 6);
        addVec(1, 1, 6'h3F, 0, 0, 0, 0, 1, WT, 7);
        addVec(1, 1, 6'h3F, 1, 0, 0, 0, 0, FR, 7);

        rst_n = 1'b0;
        abort = 1'b0; input_empty = 1'b1; grid_idle = 1'b1; core_empty = 6'h3F;
        start_seq = 1'b0; complete = 1'b0; period = '0;
        #3;
        checkOutput("reset", 0, IDLE, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], $sformatf("vec%0d", i));

        // Zero period: parked in FREERUN without ticks, even if period input changes
        for (int i = 0; i < 100; i++)
            runVec(mkVec(1, 1, 6'h3F, 0, 0, 3, 0, 0, FR, 7), $sformatf("per0_%0d", i));
        runVec(mkVec(1, 1, 6'h3F, 0, 0, 0, 1, 0, IDLE, 7), "abort_freerun");

        // Asynchronous reset takes effect without waiting for a clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, IDLE, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Period 1 ticks every cycle; drive the counter to its wrap point
        runVec(mkVec(0, 1, 6'h3F, 0, 0, 0, 0, 0, DR, 0), "wrap_drain");
        for (int i = 0; i < 4; i++) runVec(mkVec(1, 1, 6'h3F, 0, 0, 0, 0, 0, DR, 0), "wrap_quiet");
        runVec(mkVec(1, 1, 6'h3F, 0, 0, 0, 0, 1, WT, 1), "wrap_first_tick");
        runVec(mkVec(1, 1, 6'h3F, 1, 0, 1, 0, 0, FR, 1), "wrap_enter");
        runVec(mkVec(1, 1, 6'h3F, 0, 0, 1, 0, 1, FR, 2), "wrap_p1_first");
        repeat (65532) @(posedge clk);
        runVec(mkVec(1, 1, 6'h3F, 0, 0, 1, 0, 1, FR, 16'hFFFF), "wrap_ffff");
        runVec(mkVec(1, 1, 6'h3F, 0, 0, 1, 0, 1, FR, 16'h0000), "wrap_zero");
        runVec(mkVec(1, 1, 6'h3F, 0, 1, 1, 0, 0, IDLE, 16'h0000), "wrap_complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
